freelist: RTL and testbench
===========================

# freelist

Physical-register free list for the 2-way superscalar OoO core. It sits directly upstream of the maptables block and hands out up to SCALAR free physical tags per cycle; dispatch uses them to drive the RAT write ports. Commit returns each retiring instruction's previous physical tag to the list. On rollback, the list restores itself to the precise (retired) state, in step with the RRAT copy into the RAT.

## Interface
- PRF_ENTRIES, 64, number of physical registers
- RAT_ENTRIES, 32, number of architectural registers; at reset, architectural register i maps to physical tag i
- SCALAR, 2, allocation and retire width
- FL_ENTRIES, PRF_ENTRIES-RAT_ENTRIES (32), free-list depth; derived
- TAG_W, $clog2(PRF_ENTRIES) (6), tag width; derived
- clock  in  1  sole clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- rollback  in  1  branch-mispredict recovery; discards all speculative allocations
- alloc_en  in  SCALAR  dispatch slot i consumes free_tag[i] this cycle
- free_tag  out  SCALAR×TAG_W  next free tags: free_tag[i] = entry at head+i
- free_valid  out  SCALAR  free_valid[i] = (free_count > i)
- free_count  out  $clog2(FL_ENTRIES+1)  number of free tags currently available
- retire_en  in  SCALAR  commit slot i retires an instruction that allocated a tag
- retire_tag  in  SCALAR×TAG_W  previous physical tag of commit slot i, returned to the list

## Operation
- Storage is a circular buffer of FL_ENTRIES tags with three pointers: head (allocation), tail (free), and rhead (retire head). Each pointer is TAG_W-1+1 bits wide, including a wrap bit.
- Reset values:
  - entry[i] = RAT_ENTRIES+i
  - head = 0, rhead = 0, tail = FL_ENTRIES (wrap bit set, so the list is full)
  - free_count = 32, free_tag = {32,33}, free_valid = 2'b11
- Allocation:
  - Pop count n = alloc_en[0] + (alloc_en[0] & alloc_en[1]).
  - alloc_en must be contiguous from slot 0; alloc_en[1] is ignored when alloc_en[0] = 0.
  - alloc_en[i] with free_valid[i] = 0 is ignored for that slot.
  - head advances by n.
- Retire:
  - Enabled retire_tag values are compacted, slot 0 first, and written at tail and tail+1. tail advances by popcount(retire_en).
  - rhead also advances by popcount(retire_en), because each retired allocation becomes architectural.
- free_count equals tail - head, computed modulo 2·FL_ENTRIES.
- Rollback:
  - head is set to the rhead value after any same-cycle retire, i.e. rhead + popcount(retire_en).
  - alloc_en is ignored in a rollback cycle.
  - Retire in the same cycle is still applied: entries are written, and tail and rhead advance.
- Invariant: the count of tags allocated but not yet retired, plus free_count, never exceeds FL_ENTRIES.
  - A retire that would push past full is illegal; the verification engineer asserts on it.
  - Retiring more tags than have been allocated (rhead passing head) is illegal; asserted.
- No bypass: a tag freed in cycle t is visible on free_tag at t+1, never in t.

## Timing
- free_tag, free_valid and free_count are driven purely from registered state, with no combinational path from any input.
- Allocation latency: when alloc_en is sampled at edge t, the next tags appear after t.
- Retire to free latency is 1 cycle.
- Rollback takes effect at the edge on which it is sampled. Outputs show the restored list the following cycle, the same cycle in which the RAT holds the RRAT copy.
- Reset mid-operation restores all reset values at the next edge and overrides rollback, alloc_en and retire_en.
- Pointer wrap: the index is the low bits of the pointer. The wrap bit toggles on crossing FL_ENTRIES-1 to 0, and must be correct when a 2-wide pop or push straddles the boundary (e.g. indices 31 and 0).

## Test plan
- Reset check: after reset, free_tag = {32,33}, free_valid = 11, free_count = 32. The bench then holds reset for 3 cycles and confirms the values do not change.
- Drain:
  - 16 consecutive cycles with alloc_en = 11 must yield tags 32…63 in order.
  - Afterwards free_count = 0 and free_valid = 00.
  - A further alloc_en = 11 leaves state unchanged.
- Refill from empty:
  - retire_en = 11 with tags {4,10} gives free_tag = {4,10} and free_count = 2 on the next cycle.
  - retire_en = 10 with tag 7 pushes only 7.
  - Retire with simultaneous alloc while empty: the freed tag is not returned in that same cycle.
- Rollback:
  1. From reset, allocate 2 in each of 2 cycles (tags 32–35, free_count = 28).
  2. Retire slot 0 with tag 0 (free_count = 29).
  3. Assert rollback; next cycle free_tag = {33,34} and free_count = 32.
  4. Allocate 30 more tags; the last two are {63,0}, exercising wrap.
- Rollback with same-cycle retire and alloc:
  - Allocate 4 tags, then assert rollback together with retire_en = 11 (tags {1,2}) and alloc_en = 11.
  - Required result: head = rhead = 2, free_tag = {34,35}, free_count = 32, and tags 1 and 2 present at the tail.
- Illegal and reset cases:
  - alloc_en = 10 consumes nothing, and free_tag stays unchanged.
  - Asserting reset in the middle of a drain restores {32,33} and free_count = 32 on the next cycle.

Source files
------------

// File: rtl/freelist.sv
// Physical-register free list: circular buffer of free tags with allocation head,
// free tail and retire head; rollback rewinds the allocation head to the retired state.
module freelist #(
    parameter int PRF_ENTRIES = 64,
    parameter int RAT_ENTRIES = 32,
    parameter int SCALAR      = 2,
    localparam int FL_ENTRIES = PRF_ENTRIES - RAT_ENTRIES,
    localparam int TAG_W      = $clog2(PRF_ENTRIES),
    localparam int CNT_W      = $clog2(FL_ENTRIES + 1),
    localparam int IDX_W      = $clog2(FL_ENTRIES),
    localparam int PTR_W      = IDX_W + 1
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_rollback,
    input  logic [SCALAR-1:0]             i_alloc_en,
    output logic [SCALAR-1:0][TAG_W-1:0]  o_free_tag,
    output logic [SCALAR-1:0]             o_free_valid,
    output logic [CNT_W-1:0]              o_free_count,
    input  logic [SCALAR-1:0]             i_retire_en,
    input  logic [SCALAR-1:0][TAG_W-1:0]  i_retire_tag
);

    logic [TAG_W-1:0]  r_entry [FL_ENTRIES];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [PTR_W-1:0]  r_rhead;

    logic [PTR_W-1:0]  w_count;
    logic [PTR_W-1:0]  w_alloc_n;
    logic [PTR_W-1:0]  w_ret_n;
    logic              w_take;
    logic [IDX_W-1:0]  w_wr_idx [SCALAR];

    // The wrap bit makes tail - head distinguish full (FL_ENTRIES) from empty (0).
    assign w_count      = r_tail - r_head;
    assign o_free_count = CNT_W'(w_count);

    genvar gi;
    generate
        for (gi = 0; gi < SCALAR; gi++) begin : g_read
            assign o_free_tag[gi]   = r_entry[r_head[IDX_W-1:0] + IDX_W'(gi)];
            assign o_free_valid[gi] = (w_count > PTR_W'(gi));
        end
    endgenerate

    // Grants must be contiguous from slot 0 and backed by a valid free tag.
    always_comb begin
        w_alloc_n = '0;
        w_take    = 1'b1;
        w_ret_n   = '0;
        for (int s = 0; s < SCALAR; s++) begin
            w_take      = w_take & i_alloc_en[s] & o_free_valid[s];
            w_alloc_n   = w_alloc_n + PTR_W'(w_take);
            w_wr_idx[s] = r_tail[IDX_W-1:0] + w_ret_n[IDX_W-1:0];
            w_ret_n     = w_ret_n + PTR_W'(i_retire_en[s]);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < FL_ENTRIES; i++) begin
                r_entry[i] <= TAG_W'(RAT_ENTRIES + i);
            end
            r_head  <= '0;
            r_rhead <= '0;
            r_tail  <= PTR_W'(FL_ENTRIES);
        end else begin
            for (int s = 0; s < SCALAR; s++) begin
                if (i_retire_en[s]) begin
                    r_entry[w_wr_idx[s]] <= i_retire_tag[s];
                end
            end
            r_tail  <= r_tail + w_ret_n;
            r_rhead <= r_rhead + w_ret_n;
            if (i_rollback) begin
                r_head <= r_rhead + w_ret_n;
            end else begin
                r_head <= r_head + w_alloc_n;
            end
        end
    end

endmodule

// File: tb/tb_freelist.sv
// Directed bench for the free list: reset, drain, refill, rollback and wrap scenarios.
module tb_freelist;

    logic             clk;
    logic             reset;
    logic             rollback;
    logic [1:0]       alloc_en;
    logic [1:0][5:0]  free_tag;
    logic [1:0]       free_valid;
    logic [5:0]       free_count;
    logic [1:0]       retire_en;
    logic [1:0][5:0]  retire_tag;

    int checks   = 0;
    int failures = 0;

    freelist dut (
        .i_clock      (clk),
        .i_reset      (reset),
        .i_rollback   (rollback),
        .i_alloc_en   (alloc_en),
        .o_free_tag   (free_tag),
        .o_free_valid (free_valid),
        .o_free_count (free_count),
        .i_retire_en  (retire_en),
        .i_retire_tag (retire_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rollback   = 1'b0;
        alloc_en   = 2'b00;
        retire_en  = 2'b00;
        retire_tag = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            checks++;
            if (free_tag[0] !== 6'd32 || free_tag[1] !== 6'd33 || free_valid !== 2'b11 || free_count !== 6'd32) begin
                failures++;
                $display("FAIL reset_c%0d: tag={%0d,%0d} valid=%b count=%0d required tag={32,33} valid=11 count=32",
                         c, free_tag[0], free_tag[1], free_valid, free_count);
            end
        end
        reset = 1'b0;
        $display("reset: tag={%0d,%0d} valid=%b count=%0d", free_tag[0], free_tag[1], free_valid, free_count);
    endtask

    task automatic test_drain();
        do_reset();
        for (int c = 0; c < 16; c++) begin
            checks++;
            if (free_tag[0] !== 6'(32 + 2*c) || free_tag[1] !== 6'(33 + 2*c)) begin
                failures++;
                $display("FAIL drain_c%0d: tag={%0d,%0d} required {%0d,%0d}",
                         c, free_tag[0], free_tag[1], 32 + 2*c, 33 + 2*c);
            end
            alloc_en = 2'b11;
            cycle();
        end
        alloc_en = 2'b00;
        checks++;
        if (free_count !== 6'd0 || free_valid !== 2'b00) begin
            failures++;
            $display("FAIL drain_empty: count=%0d valid=%b required count=0 valid=00", free_count, free_valid);
        end
        alloc_en = 2'b11;
        cycle();
        alloc_en = 2'b00;
        checks++;
        if (free_count !== 6'd0 || free_valid !== 2'b00 || free_tag[0] !== 6'd32 || free_tag[1] !== 6'd33) begin
            failures++;
            $display("FAIL drain_alloc_empty: count=%0d valid=%b tag={%0d,%0d} required count=0 valid=00 tag={32,33}",
                     free_count, free_valid, free_tag[0], free_tag[1]);
        end
        $display("drain: count=%0d valid=%b", free_count, free_valid);
    endtask

    // Runs from the empty state left by test_drain.
    task automatic test_refill();
        retire_en  = 2'b11;
        retire_tag[0] = 6'd4;
        retire_tag[1] = 6'd10;
        cycle();
        idle_inputs();
        checks++;
        if (free_tag[0] !== 6'd4 || free_tag[1] !== 6'd10 || free_count !== 6'd2) begin
            failures++;
            $display("FAIL refill_two: tag={%0d,%0d} count=%0d required tag={4,10} count=2",
                     free_tag[0], free_tag[1], free_count);
        end
        retire_en     = 2'b10;
        retire_tag[0] = 6'd55;
        retire_tag[1] = 6'd7;
        cycle();
        idle_inputs();
        checks++;
        if (free_count !== 6'd3) begin
            failures++;
            $display("FAIL refill_one_count: count=%0d required 3", free_count);
        end
        alloc_en = 2'b11;
        cycle();
        checks++;
        if (free_tag[0] !== 6'd7 || free_count !== 6'd1 || free_valid !== 2'b01) begin
            failures++;
            $display("FAIL refill_one_tag: tag0=%0d count=%0d valid=%b required tag0=7 count=1 valid=01",
                     free_tag[0], free_count, free_valid);
        end
        cycle();
        checks++;
        if (free_count !== 6'd0) begin
            failures++;
            $display("FAIL refill_partial_alloc: count=%0d required 0", free_count);
        end
        retire_en     = 2'b01;
        retire_tag[0] = 6'd9;
        cycle();
        idle_inputs();
        checks++;
        if (free_count !== 6'd1 || free_tag[0] !== 6'd9 || free_valid !== 2'b01) begin
            failures++;
            $display("FAIL refill_no_bypass: count=%0d tag0=%0d valid=%b required count=1 tag0=9 valid=01",
                     free_count, free_tag[0], free_valid);
        end
        $display("refill: tag0=%0d count=%0d", free_tag[0], free_count);
    endtask

    task automatic test_rollback();
        do_reset();
        alloc_en = 2'b11;
        cycle();
        cycle();
        alloc_en = 2'b00;
        checks++;
        if (free_tag[0] !== 6'd36 || free_count !== 6'd28) begin
            failures++;
            $display("FAIL rb_alloc4: tag0=%0d count=%0d required tag0=36 count=28", free_tag[0], free_count);
        end
        retire_en     = 2'b01;
        retire_tag[0] = 6'd0;
        cycle();
        idle_inputs();
        checks++;
        if (free_count !== 6'd29) begin
            failures++;
            $display("FAIL rb_retire: count=%0d required 29", free_count);
        end
        rollback = 1'b1;
        cycle();
        rollback = 1'b0;
        checks++;
        if (free_tag[0] !== 6'd33 || free_tag[1] !== 6'd34 || free_count !== 6'd32) begin
            failures++;
            $display("FAIL rb_restore: tag={%0d,%0d} count=%0d required tag={33,34} count=32",
                     free_tag[0], free_tag[1], free_count);
        end
        alloc_en = 2'b11;
        for (int c = 0; c < 15; c++) cycle();
        alloc_en = 2'b00;
        checks++;
        if (free_tag[0] !== 6'd63 || free_tag[1] !== 6'd0 || free_count !== 6'd2) begin
            failures++;
            $display("FAIL rb_wrap_tags: tag={%0d,%0d} count=%0d required tag={63,0} count=2",
                     free_tag[0], free_tag[1], free_count);
        end
        alloc_en = 2'b11;
        cycle();
        alloc_en = 2'b00;
        checks++;
        if (free_count !== 6'd0 || free_valid !== 2'b00) begin
            failures++;
            $display("FAIL rb_wrap_pop: count=%0d valid=%b required count=0 valid=00", free_count, free_valid);
        end
        $display("rollback: count=%0d valid=%b", free_count, free_valid);
    endtask

    task automatic test_rollback_retire();
        do_reset();
        alloc_en = 2'b11;
        cycle();
        cycle();
        rollback      = 1'b1;
        retire_en     = 2'b11;
        retire_tag[0] = 6'd1;
        retire_tag[1] = 6'd2;
        cycle();
        idle_inputs();
        checks++;
        if (free_tag[0] !== 6'd34 || free_tag[1] !== 6'd35 || free_count !== 6'd32) begin
            failures++;
            $display("FAIL rbr_restore: tag={%0d,%0d} count=%0d required tag={34,35} count=32",
                     free_tag[0], free_tag[1], free_count);
        end
        alloc_en = 2'b11;
        for (int c = 0; c < 15; c++) cycle();
        alloc_en = 2'b00;
        checks++;
        if (free_tag[0] !== 6'd1 || free_tag[1] !== 6'd2 || free_count !== 6'd2) begin
            failures++;
            $display("FAIL rbr_tail_tags: tag={%0d,%0d} count=%0d required tag={1,2} count=2",
                     free_tag[0], free_tag[1], free_count);
        end
        $display("rollback_retire: tag={%0d,%0d} count=%0d", free_tag[0], free_tag[1], free_count);
    endtask

    task automatic test_illegal_alloc();
        do_reset();
        alloc_en = 2'b10;
        cycle();
        checks++;
        if (free_tag[0] !== 6'd32 || free_tag[1] !== 6'd33 || free_count !== 6'd32) begin
            failures++;
            $display("FAIL alloc10_reset: tag={%0d,%0d} count=%0d required tag={32,33} count=32",
                     free_tag[0], free_tag[1], free_count);
        end
        alloc_en = 2'b01;
        cycle();
        alloc_en = 2'b10;
        cycle();
        alloc_en = 2'b00;
        checks++;
        if (free_tag[0] !== 6'd33 || free_tag[1] !== 6'd34 || free_count !== 6'd31) begin
            failures++;
            $display("FAIL alloc10_mid: tag={%0d,%0d} count=%0d required tag={33,34} count=31",
                     free_tag[0], free_tag[1], free_count);
        end
        $display("illegal_alloc: tag={%0d,%0d} count=%0d", free_tag[0], free_tag[1], free_count);
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        alloc_en = 2'b11;
        for (int c = 0; c < 5; c++) cycle();
        checks++;
        if (free_count !== 6'd22) begin
            failures++;
            $display("FAIL mid_drain_count: count=%0d required 22", free_count);
        end
        reset         = 1'b1;
        rollback      = 1'b1;
        retire_en     = 2'b11;
        retire_tag[0] = 6'd5;
        retire_tag[1] = 6'd6;
        cycle();
        reset = 1'b0;
        idle_inputs();
        checks++;
        if (free_tag[0] !== 6'd32 || free_tag[1] !== 6'd33 || free_count !== 6'd32 || free_valid !== 2'b11) begin
            failures++;
            $display("FAIL mid_drain_reset: tag={%0d,%0d} count=%0d valid=%b required tag={32,33} count=32 valid=11",
                     free_tag[0], free_tag[1], free_count, free_valid);
        end
        $display("reset_mid_drain: tag={%0d,%0d} count=%0d", free_tag[0], free_tag[1], free_count);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_drain();
        test_refill();
        test_rollback();
        test_rollback_retire();
        test_illegal_alloc();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
